// File: rtl/rr_arb_4_1_if.sv
// Handshake bundle between four producers, the round-robin arbiter and
// the downstream consumer (4:1 mux stage or any valid/ready sink).
interface rr_arb_4_1_if #(
    parameter int WIDTH = 4
) ();
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;

    // Environment side: producers drive words, consumer drives out_ready
    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    // Arbiter side
    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_4_1.sv
// Round-robin arbiter with an output register feeding a 4:1 mux stage.
// One of four producers is granted per transfer, scanning from the
// priority pointer upward (mod 4); the winning word and its 2-bit source
// index are registered. A pending word may be replaced in the same cycle
// it is consumed, giving one word per cycle throughput.
module rr_arb_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    rr_arb_4_1_if.slave   bus
);

    logic [1:0]       ptr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [1:0]       out_sel_r;

    logic             load_en_s;
    logic [3:0]       rot_s;
    logic [2:0]       first_s;
    logic             grant_vld_s;
    logic [1:0]       grant_idx_s;
    logic [3:0]       grant_oh_s;
    logic [WIDTH-1:0] grant_data_s;

    // Lowest set bit of v as {found, index}; index is 0 when nothing is set.
    function automatic logic [2:0] first_set(input logic [3:0] v);
        logic [2:0] r;
        if (v[0]) begin
            r = 3'b100;
        end else if (v[1]) begin
            r = 3'b101;
        end else if (v[2]) begin
            r = 3'b110;
        end else if (v[3]) begin
            r = 3'b111;
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // Output register can take a new word when empty or being drained now
    assign load_en_s = ~out_valid_r | bus.out_ready;

    // Rotate requests so bit 0 is the channel the pointer currently favours
    always_comb begin
        rot_s = 4'b0000;
        case (ptr_r)
            2'd0:    rot_s = bus.in_valid;
            2'd1:    rot_s = {bus.in_valid[0],   bus.in_valid[3:1]};
            2'd2:    rot_s = {bus.in_valid[1:0], bus.in_valid[3:2]};
            2'd3:    rot_s = {bus.in_valid[2:0], bus.in_valid[3]};
            default: rot_s = 4'b0000;
        endcase
    end

    // Grant decision: first requester from the pointer, only when loadable and out of reset
    always_comb begin
        first_s     = first_set(rot_s);
        grant_vld_s = first_s[2] & load_en_s & ~rst;
        grant_idx_s = ptr_r + first_s[1:0];
        if (grant_vld_s) begin
            grant_oh_s = 4'b0001 << grant_idx_s;
        end else begin
            grant_oh_s = 4'b0000;
        end
    end

    // Select the granted channel's word for loading
    always_comb begin
        grant_data_s = {WIDTH{1'b0}};
        case (grant_idx_s)
            2'd0:    grant_data_s = bus.in_data0;
            2'd1:    grant_data_s = bus.in_data1;
            2'd2:    grant_data_s = bus.in_data2;
            2'd3:    grant_data_s = bus.in_data3;
            default: grant_data_s = {WIDTH{1'b0}};
        endcase
    end

    // Output register and pointer: load on grant, empty on a drain, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= 2'd0;
            ptr_r       <= 2'd0;
        end else if (grant_vld_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_sel_r   <= grant_idx_s;
            ptr_r       <= grant_idx_s + 2'd1;
        end else if (load_en_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = grant_oh_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;

endmodule
